eth_stream_packer: RTL and testbench
====================================

// Module: eth_stream_packer
// PURPOSE
//  Downstream consumer of the AXI-to-stream mirror output. Buffers raw AXI-Stream beats and
//  packs them into framed bursts: one header beat, then 1..MAX_BEATS payload beats.
//  The last payload beat carries TLAST. Feeds the Ethernet TX path.
//  Flushes a partial frame on upstream TLAST or after an idle timeout.
// PARAMETERS
//  DATA_W      64    stream data width; must be >= 64 (header occupies bits [63:0])
//  MAX_BEATS   16    max payload beats per frame; 1..FIFO_DEPTH
//  FIFO_DEPTH  32    input buffer depth, power of 2
//  TIMEOUT     256   idle cycles before a partial frame is flushed; >= 2
// PORTS
//  aclk              in   1              clock, all logic rising-edge
//  aresetn           in   1              asynchronous active-low reset
//  s_axis_tdata      in   DATA_W         payload from AXI-to-stream stage
//  s_axis_tvalid     in   1              input beat valid
//  s_axis_tlast      in   1              end of mirrored transaction -> flush request
//  s_axis_tready     out  1              input ready = FIFO not full
//  m_axis_tdata      out  DATA_W         header or payload beat
//  m_axis_tvalid     out  1              output beat valid
//  m_axis_tlast      out  1              last payload beat of frame
//  m_axis_tready     in   1              downstream ready
//  DBG_state         out  2              FSM state encoding (IDLE=0, HEADER=1, PAYLOAD=2)
//  DBG_frames_sent   out  16             count of completed frames, wraps
// BEHAVIOUR
//  Reset: all outputs 0 except s_axis_tready=0 while in reset, 1 on first cycle after.
//    FIFO emptied; seq, timer, flush flag and frame counter cleared; FSM=IDLE.
//    Reset mid-frame: the frame is abandoned and no TLAST is emitted.
//  Input: beat accepted when tvalid&tready; pushed to FIFO. tready=!full (registered count).
//  Flush flag: set when an accepted beat has tlast=1; cleared when a frame starts.
//  Timer: counts cycles in IDLE while 0<count<MAX_BEATS.
//    Cleared on an accepted input beat or on frame start.
//    Saturates at TIMEOUT-1 and raises the timeout condition.
//  FSM:
//    IDLE->HEADER when count>=MAX_BEATS, or (flush flag & count>0), or (timeout & count>0).
//      On the transition, latch len=min(count,MAX_BEATS).
//    HEADER: tvalid=1, tdata[63:0]={16'hE7A5, seq[15:0], 16'(len), 16'h0000}, upper bits 0.
//      Moves to PAYLOAD on handshake.
//    PAYLOAD: tvalid=1, tdata=FIFO head (first-word-fall-through), tlast=(remaining==1).
//      Each handshake pops the FIFO and decrements remaining.
//      On the last handshake: seq++ (wraps FFFF->0000), frames_sent++, ->IDLE.
//  Latency: the beat that makes count==MAX_BEATS, accepted at edge k, produces the header
//    valid after edge k+1. Back-to-back frames lose one IDLE cycle between them.
//  AXIS rules: tvalid and tdata stay stable until tready. No tvalid without data.
//    Input is never dropped.
//  Simultaneous push/pop in PAYLOAD: count unchanged; a full FIFO with a pop accepts input
//    only next cycle (tready uses the registered count).
//  The flush flag set while in HEADER/PAYLOAD is kept for the next frame.
//  len is never 0; the header is not emitted for an empty FIFO.
// STRUCTURE
//  Package eth_packer_pkg: state_t enum, HDR_MAGIC=16'hE7A5, header field offsets.
//  Sub-module sync_fifo_fwft (DATA_W, FIFO_DEPTH): push/pop/full/empty/count, async reset.
//  Top: FSM, timer, seq/len/remaining registers, output mux.
// TESTING
//  1. Reset, then 16 beats 0..15 back-to-back, m_tready=1 ->
//     header {E7A5,0000,0010,0000}, then data 0..15, tlast on 15, DBG_frames_sent=1.
//  2. 5 beats, last with s_tlast=1 -> header len=5 immediately, tlast on 5th, seq=0001 next.
//  3. 3 beats, no tlast, then idle -> header len=3 appears 256 cycles after the 3rd beat.
//  4. 40 beats with m_tready=0 -> s_tready drops after 32 accepted.
//     Release with random 50% m_tready -> frames len 16,16,8, data in order, nothing lost.
//  5. Force seq=FFFF via 65536 one-beat frames or a backdoor -> next header seq=0000.
//  6. Assert aresetn mid-PAYLOAD (beat 7 of 16) -> outputs 0 asynchronously, FIFO empty.
//     Next frame header seq=0000.

Source files
------------

// File: rtl/eth_packer_pkg.sv
// Shared types and header layout for the Ethernet stream packer.
package eth_packer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  localparam logic [15:0] HDR_MAGIC     = 16'hE7A5;
  localparam int          HDR_MAGIC_LSB = 48;
  localparam int          HDR_SEQ_LSB   = 32;
  localparam int          HDR_LEN_LSB   = 16;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; rdata always shows the head entry.
module sync_fifo_fwft #(
  parameter  int DATA_W     = 64,
  parameter  int FIFO_DEPTH = 32,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/eth_stream_packer.sv
// Packs raw AXI-Stream beats into header + 1..MAX_BEATS payload frames,
// flushing early on upstream TLAST or after an idle timeout.
module eth_stream_packer
  import eth_packer_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int MAX_BEATS  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [1:0]        DBG_state,
  output logic [15:0]       DBG_frames_sent
);

  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              LW       = $clog2(MAX_BEATS + 1);
  localparam int              TW       = $clog2(TIMEOUT);
  localparam logic [AW:0]     MAX_CNT  = (AW+1)'(MAX_BEATS);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

  state_t            state;
  logic [15:0]       seq, frames_sent;
  logic [LW-1:0]     len, remaining, take_len;
  logic [TW-1:0]     timer;
  logic              flush, rdy, timeout, start, push, pop;
  logic [DATA_W-1:0] fifo_head, hdr;
  logic              fifo_full, fifo_empty;
  logic [AW:0]       fifo_count;

  sync_fifo_fwft #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .wdata   (s_axis_tdata),
    .pop     (pop),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // rdy holds tready low through reset and releases it on the first clock after.
  assign s_axis_tready = rdy & ~fifo_full;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = (state == PAYLOAD) & m_axis_tready & ~fifo_empty;
  assign timeout       = (timer == TMO_LAST);
  assign start         = (state == IDLE) &&
                         ((fifo_count >= MAX_CNT) || ((flush || timeout) && fifo_count != '0));
  assign take_len      = (fifo_count >= MAX_CNT) ? LW'(MAX_BEATS) : LW'(fifo_count);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy   <= 1'b0;
      flush <= 1'b0;
      timer <= '0;
    end else begin
      rdy <= 1'b1;
      // A tlast beat landing on the frame-start cycle is not in that frame, so it wins.
      if (push && s_axis_tlast) flush <= 1'b1;
      else if (start)           flush <= 1'b0;
      if (push || start)
        timer <= '0;
      else if (state == IDLE && fifo_count != '0 && fifo_count < MAX_CNT && !timeout)
        timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      seq         <= '0;
      len         <= '0;
      remaining   <= '0;
      frames_sent <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= HEADER;
          len       <= take_len;
          remaining <= take_len;
        end
        HEADER: if (m_axis_tready) state <= PAYLOAD;
        PAYLOAD: if (m_axis_tready) begin
          remaining <= remaining - 1'b1;
          if (remaining == LW'(1)) begin
            seq         <= seq + 1'b1;
            frames_sent <= frames_sent + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    hdr = '0;
    hdr[HDR_MAGIC_LSB +: 16] = HDR_MAGIC;
    hdr[HDR_SEQ_LSB   +: 16] = seq;
    hdr[HDR_LEN_LSB   +: 16] = 16'(len);
  end

  always_comb begin
    m_axis_tdata = '0;
    if (state == HEADER)       m_axis_tdata = hdr;
    else if (state == PAYLOAD) m_axis_tdata = fifo_head;
  end

  assign m_axis_tvalid   = (state == HEADER) || (state == PAYLOAD);
  assign m_axis_tlast    = (state == PAYLOAD) && (remaining == LW'(1));
  assign DBG_state       = state;
  assign DBG_frames_sent = frames_sent;

endmodule

// File: tb/tb_eth_stream_packer.sv
// Directed + random bench: input beats go to a queue, output beats are parsed
// into frames and compared against header rules and the input order.
module tb_eth_stream_packer;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
  logic [1:0]  dbg_state;
  logic [15:0] dbg_frames;

  int          errors = 0, checks = 0, exp_frames = 0;
  logic [15:0] exp_seq = '0;
  logic [63:0] in_q[$];
  beat_t       out_q[$];
  logic        a_done = 1'b0;

  eth_stream_packer dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tlast    (s_tlast),
    .s_axis_tready   (s_tready),
    .m_axis_tdata    (m_tdata),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tlast    (m_tlast),
    .m_axis_tready   (m_tready),
    .DBG_state       (dbg_state),
    .DBG_frames_sent (dbg_frames)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: sample at negedge, commit at the following edge only if
  // reset did not intervene; also checks AXIS hold-while-stalled.
  logic        pend_v = 1'b0, prev_stall = 1'b0;
  beat_t       pend_b;
  logic [63:0] prev_d = '0;

  always @(negedge aclk) begin
    if (aresetn && prev_stall) begin
      chk("hold_valid", 64'(m_tvalid), 64'd1);
      chk("hold_data", m_tdata, prev_d);
    end
    prev_stall <= aresetn && m_tvalid && !m_tready;
    prev_d     <= m_tdata;
    pend_v     <= aresetn && m_tvalid && m_tready;
    pend_b     <= '{m_tdata, m_tlast};
  end

  always @(posedge aclk) begin
    if (pend_v && aresetn) out_q.push_back(pend_b);
  end

  task automatic sync();
    @(posedge aclk); #1;
  endtask

  // Entered at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [63:0] d, input logic last);
    int   n = 0;
    logic ok = 1'b0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
    do begin
      @(negedge aclk); ok = s_tready;
      @(posedge aclk); #1; n++;
    end while (!ok && n < 500);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL send_timeout: observed=not_accepted expected=accepted");
    end
    if (ok) in_q.push_back(d);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c = 0;
    while (out_q.size() < n && c < budget) begin
      @(negedge aclk); c++;
    end
    checks++;
    assert (out_q.size() >= n) else begin
      errors++;
      $error("FAIL wait_beats: observed=%0d expected=%0d", out_q.size(), n);
    end
  endtask

  task automatic expect_frame(input int len);
    beat_t       b;
    logic [63:0] d;
    checks++;
    assert (out_q.size() >= len + 1) else begin
      errors++;
      $error("FAIL frame_size: observed=%0d expected=%0d", out_q.size(), len + 1);
    end
    if (out_q.size() < len + 1) return;
    b = out_q.pop_front();
    chk("hdr_magic", 64'(b.d[63:48]), 64'hE7A5);
    chk("hdr_seq",   64'(b.d[47:32]), 64'(exp_seq));
    chk("hdr_len",   64'(b.d[31:16]), 64'(len));
    chk("hdr_rsvd",  64'(b.d[15:0]),  64'd0);
    chk("hdr_last",  64'(b.l),        64'd0);
    for (int i = 0; i < len; i++) begin
      b = out_q.pop_front();
      d = (in_q.size() > 0) ? in_q.pop_front() : 'x;
      chk("payload", b.d, d);
      chk("tlast", 64'(b.l), 64'(i == len - 1));
    end
    exp_seq = exp_seq + 16'd1;
    exp_frames++;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int          n, nl;
    logic [63:0] d33;

    #1 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_mvalid", 64'(m_tvalid), 0);
    chk("rst_mlast",  64'(m_tlast),  0);
    chk("rst_mdata",  m_tdata,       0);
    chk("rst_sready", 64'(s_tready), 0);
    chk("rst_state",  64'(dbg_state), 0);
    chk("rst_frames", 64'(dbg_frames), 0);
    #2 aresetn = 1'b1;
    sync();
    chk("rdy_after_reset", 64'(s_tready), 1);

    // Full frame from 16 back-to-back beats; header one cycle after the 16th.
    for (int i = 0; i < 16; i++) send_beat(64'(i), 1'b0);
    s_tvalid = 1'b0;
    @(negedge aclk); chk("t1_lat_idle", 64'(m_tvalid), 0);
    @(negedge aclk); chk("t1_lat_hdr", 64'(m_tvalid), 1);
    chk("t1_state_hdr", 64'(dbg_state), 1);
    chk("t1_hdr_word", m_tdata, 64'hE7A5_0000_0010_0000);
    wait_beats(17, 100);
    expect_frame(16);
    chk("t1_frames", 64'(dbg_frames), 64'(exp_frames));

    // tlast flush
    sync();
    for (int i = 0; i < 5; i++) send_beat(rnd64(), i == 4);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    @(negedge aclk); chk("t2_lat_idle", 64'(m_tvalid), 0);
    @(negedge aclk); chk("t2_lat_hdr", 64'(m_tvalid), 1);
    wait_beats(6, 100);
    expect_frame(5);
    chk("t2_frames", 64'(dbg_frames), 64'(exp_frames));

    // Idle timeout flush
    sync();
    for (int i = 0; i < 3; i++) send_beat(rnd64(), 1'b0);
    s_tvalid = 1'b0;
    n = 0;
    do begin @(negedge aclk); n++; end while (!m_tvalid && n < 400);
    chk("t3_timeout_cycles", 64'(n - 1), 64'd256);
    wait_beats(4, 50);
    expect_frame(3);
    chk("t3_frames", 64'(dbg_frames), 64'(exp_frames));

    // Back-pressure: fill the FIFO, then drain with random downstream ready.
    sync();
    m_tready = 1'b0;
    for (int i = 0; i < 32; i++) send_beat(rnd64(), 1'b0);
    chk("t4_accepted", 64'(in_q.size()), 64'd32);
    d33 = rnd64();
    s_tdata = d33; s_tvalid = 1'b1; s_tlast = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      chk("t4_full_sready", 64'(s_tready), 0);
    end
    chk("t4_state_hdr", 64'(dbg_state), 1);
    sync();
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat((i == 0) ? d33 : rnd64(), 1'b0);
        s_tvalid = 1'b0;
        a_done = 1'b1;
      end
      begin
        int c = 0;
        while ((!a_done || out_q.size() < 43) && c < 4000) begin
          @(posedge aclk); #1;
          m_tready = 1'($urandom_range(0, 1));
          c++;
        end
        m_tready = 1'b1;
      end
    join
    wait_beats(43, 10);
    expect_frame(16);
    expect_frame(16);
    expect_frame(8);
    chk("t4_frames", 64'(dbg_frames), 64'(exp_frames));
    chk("t4_in_drained", 64'(in_q.size()), 0);

    // Sequence wrap via backdoor
    force dut.seq = 16'hFFFF;
    sync();
    release dut.seq;
    exp_seq = 16'hFFFF;
    send_beat(rnd64(), 1'b1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    wait_beats(2, 50);
    expect_frame(1);
    sync();
    send_beat(rnd64(), 1'b1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    wait_beats(2, 50);
    chk("t5_wrapped_seq", 64'(out_q.size() > 0 ? out_q[0].d[47:32] : 16'h1234), 64'd0);
    expect_frame(1);
    chk("t5_frames", 64'(dbg_frames), 64'(exp_frames));

    // Reset while payload beat 7 of 16 is on the bus.
    sync();
    for (int i = 0; i < 16; i++) send_beat(rnd64(), 1'b0);
    s_tvalid = 1'b0;
    wait_beats(7, 100);
    #1 aresetn = 1'b0;
    #1;
    chk("t6_mvalid", 64'(m_tvalid), 0);
    chk("t6_mlast",  64'(m_tlast),  0);
    chk("t6_mdata",  m_tdata,       0);
    chk("t6_sready", 64'(s_tready), 0);
    chk("t6_state",  64'(dbg_state), 0);
    chk("t6_frames", 64'(dbg_frames), 0);
    nl = 0;
    foreach (out_q[i]) nl += int'(out_q[i].l);
    chk("t6_no_tlast", 64'(nl), 0);
    chk("t6_partial_beats", 64'(out_q.size()), 64'd7);
    out_q.delete(); in_q.delete();
    exp_seq = '0; exp_frames = 0;
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b1;
    sync();
    chk("t6_rdy_after", 64'(s_tready), 1);
    send_beat(rnd64(), 1'b0);
    send_beat(rnd64(), 1'b1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    wait_beats(3, 100);
    expect_frame(2);
    chk("t6_frames_after", 64'(dbg_frames), 64'(exp_frames));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
